// File: rtl/kd_node_engine.sv
// kd_node_engine: per-node kd-tree compute element for the k-means datapath.
// It runs one operation per valid/ready transaction:
//   sort  - three compare-and-swap steps over (left, parent, right) on the split axis
//   query - serial Manhattan distance to the parent center, then the best-candidate
//           update and the branch decisions
// Every input is captured at accept, so the caller may change its inputs straight away.
module kd_node_engine #(
  parameter  int DIM    = 3,
  parameter  int DATA_W = 8,
  localparam int AXIS_W = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int DIST_W = DATA_W + $clog2(DIM),
  localparam int CTR_W  = DIM * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op,
  input  logic              left_en,
  input  logic              right_en,
  input  logic [AXIS_W-1:0] axis,
  input  logic [CTR_W-1:0]  left,
  input  logic [CTR_W-1:0]  parent,
  input  logic [CTR_W-1:0]  right,
  input  logic [CTR_W-1:0]  query,
  input  logic [CTR_W-1:0]  best_in,
  input  logic [DIST_W-1:0] best_dist_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTR_W-1:0]  new_left,
  output logic [CTR_W-1:0]  new_parent,
  output logic [CTR_W-1:0]  new_right,
  output logic [CTR_W-1:0]  best_out,
  output logic [DIST_W-1:0] best_dist_out,
  output logic              first_dir,
  output logic              other_branch,
  output logic              stable,
  output logic [1:0]        swap_cnt
);

  typedef enum logic [1:0] {IDLE, SORT, DIST, DONE} state_t;

  localparam logic [AXIS_W-1:0] LAST_D = AXIS_W'(DIM - 1);

  state_t              state;
  logic [CTR_W-1:0]    cl, cp, cr, cq, cbest;
  logic [DIST_W-1:0]   cbd;
  logic [AXIS_W-1:0]   caxis;
  logic                cl_en, cr_en;
  logic [1:0]          step;
  logic [AXIS_W-1:0]   dcnt;
  logic [DIST_W-1:0]   acc;
  logic [DATA_W-1:0]   axis_dist;

  // Selects coordinate idx. An out-of-range index reads as zero, so an illegal
  // axis still gives a defined result and the operation still completes.
  function automatic logic [DATA_W-1:0] coord(input logic [CTR_W-1:0] v,
                                              input logic [AXIS_W-1:0] idx);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int d = 0; d < DIM; d++)
      if (idx == AXIS_W'(d)) r = v[d*DATA_W +: DATA_W];
    return r;
  endfunction

  // Per-coordinate unsigned absolute difference between query and parent
  logic [DIM-1:0][DATA_W-1:0] diff;
  for (genvar g = 0; g < DIM; g++) begin : g_lane
    logic [DATA_W-1:0] qa, pa;
    assign qa      = cq[g*DATA_W +: DATA_W];
    assign pa      = cp[g*DATA_W +: DATA_W];
    assign diff[g] = (qa > pa) ? (qa - pa) : (pa - qa);
  end

  // Distance datapath: current term, next accumulator, next axis distance, best update
  logic [DATA_W-1:0] term, ax_next;
  logic [DIST_W-1:0] acc_next, bd_new;
  logic              upd;
  always_comb begin
    term = '0;
    for (int d = 0; d < DIM; d++)
      if (dcnt == AXIS_W'(d)) term = diff[d];
    acc_next = acc + DIST_W'(term);
    ax_next  = (dcnt == caxis) ? term : axis_dist;
    upd      = (acc_next < cbd);
    bd_new   = upd ? acc_next : cbd;
  end

  // Sort datapath: steps 0 and 2 compare (L,P), step 1 compares (P,R); ties never swap
  logic lp_swap, pr_swap, do_swap;
  always_comb begin
    lp_swap = coord(cl, caxis) > coord(cp, caxis);
    pr_swap = coord(cp, caxis) > coord(cr, caxis);
    case (step)
      2'd1:    do_swap = cr_en & pr_swap;
      default: do_swap = cl_en & lp_swap;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign new_left   = cl;
  assign new_parent = cp;
  assign new_right  = cr;

  // Control FSM: capture, sort or distance steps, then hold the result until it is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cl            <= '0;
      cp            <= '0;
      cr            <= '0;
      cq            <= '0;
      cbest         <= '0;
      cbd           <= '0;
      caxis         <= '0;
      cl_en         <= 1'b0;
      cr_en         <= 1'b0;
      step          <= '0;
      dcnt          <= '0;
      acc           <= '0;
      axis_dist     <= '0;
      best_out      <= '0;
      best_dist_out <= '0;
      first_dir     <= 1'b0;
      other_branch  <= 1'b0;
      stable        <= 1'b0;
      swap_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cl        <= left;
          cp        <= parent;
          cr        <= right;
          cq        <= query;
          cbest     <= best_in;
          cbd       <= best_dist_in;
          caxis     <= axis;
          cl_en     <= left_en;
          cr_en     <= right_en;
          step      <= '0;
          dcnt      <= '0;
          acc       <= '0;
          axis_dist <= '0;
          swap_cnt  <= '0;
          state     <= op ? DIST : SORT;
        end
        SORT: begin
          if (do_swap) begin
            if (step == 2'd1) begin
              cp <= cr;
              cr <= cp;
            end else begin
              cl <= cp;
              cp <= cl;
            end
            swap_cnt <= swap_cnt + 2'd1;
          end
          step <= step + 2'd1;
          if (step == 2'd2) begin
            stable        <= (swap_cnt == 2'd0) && !do_swap;
            first_dir     <= 1'b0;
            other_branch  <= 1'b0;
            best_out      <= cbest;
            best_dist_out <= cbd;
            state         <= DONE;
          end
        end
        DIST: begin
          acc       <= acc_next;
          axis_dist <= ax_next;
          dcnt      <= dcnt + 1'b1;
          if (dcnt == LAST_D) begin
            best_out      <= upd ? cp : cbest;
            best_dist_out <= bd_new;
            first_dir     <= coord(cq, caxis) < coord(cp, caxis);
            other_branch  <= DIST_W'(ax_next) < bd_new;
            stable        <= 1'b1;
            swap_cnt      <= '0;
            state         <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
